// File: rtl/ed25519_pkg.sv
// Shared Ed25519 field constants, the converter state type and the
// field-reduction helper used by the modular multiplier.
package ed25519_pkg;

  localparam int WIDTH = 255;

  // p = 2^255 - 19
  localparam logic [WIDTH-1:0] P =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  // Inversion exponent p - 2
  localparam logic [WIDTH-1:0] P_MINUS_2 =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb;

  // Twisted Edwards curve constant d
  localparam logic [WIDTH-1:0] D =
    255'h52036cee_2b6ffe73_8cc74079_7779e898_00700a4d_4141d8ab_75eb4dca_135978a3;

  // Base point G
  localparam logic [WIDTH-1:0] GX =
    255'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
  localparam logic [WIDTH-1:0] GY =
    255'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQR  = 3'd1,
    S_MULZ = 3'd2,
    S_MULX = 3'd3,
    S_MULY = 3'd4
  } p2a_state_t;

  // Reduce a product of two reduced elements into [0,p).
  // 2^255 == 19 (mod p), so the high half folds back multiplied by 19.
  // Two folds leave a value below 2p; one conditional subtract finishes.
  function automatic logic [WIDTH-1:0] reduce_p(input logic [2*WIDTH-1:0] prod);
    logic [WIDTH+5:0] s1;
    logic [WIDTH:0]   s2;
    s1 = {6'd0, prod[WIDTH-1:0]} + ({6'd0, prod[2*WIDTH-1:WIDTH]} * 261'd19);
    s2 = {1'b0, s1[WIDTH-1:0]} + ({250'd0, s1[WIDTH+5:WIDTH]} * 256'd19);
    if (s2 >= {1'b0, P}) begin
      s2 = s2 - {1'b0, P};
    end else begin
      s2 = s2;
    end
    return s2[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/mod_mul.sv
// 255-bit modular multiplier mod 2^255-19. Operands are taken on i_start,
// the reduced product and o_finished appear one cycle later.
module mod_mul
  import ed25519_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_r,
  output logic             o_finished
);

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   red_s;
  logic [WIDTH-1:0]   res_r;
  logic               fin_r;

  // Full product and its reduction
  always_comb begin
    prod_s = {255'd0, i_a} * {255'd0, i_b};
    red_s  = reduce_p(prod_s);
  end

  // Capture the result and raise done one cycle after start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_r <= 255'd0;
      fin_r <= 1'b0;
    end else begin
      fin_r <= i_start;
      if (i_start) begin
        res_r <= red_s;
      end else begin
        res_r <= res_r;
      end
    end
  end

  assign o_r        = res_r;
  assign o_finished = fin_r;

endmodule

// File: rtl/proj_to_affine.sv
// Projective (X:Y:Z) to affine (X/Z, Y/Z) conversion over GF(2^255-19).
// Z^-1 = Z^(p-2) by left-to-right square-and-multiply, then X*Z^-1 and
// Y*Z^-1, all on a single shared modular multiplier.
module proj_to_affine
  import ed25519_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_z,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic             o_busy,
  output logic             o_error,
  output logic             o_finished
);

  p2a_state_t state_r, state_nxt_s;

  logic [WIDTH-1:0] x_r, y_r, z_r, acc_r, xh_r;
  logic [7:0]       bit_idx_r;
  logic             z_zero_r;

  logic             mul_start_r;
  logic [WIDTH-1:0] mul_a_r, mul_b_r;
  logic [WIDTH-1:0] mul_res_s;
  logic             mul_done_s;

  logic [WIDTH-1:0] ox_r, oy_r;
  logic             busy_r, err_r, fin_r;

  logic             accept_s, exp_bit_s, last_bit_s;
  logic             issue_s, acc_ld_s, dec_s, xh_ld_s, done_out_s;
  logic [WIDTH-1:0] op_a_s, op_b_s;

  // A start landing on the o_finished cycle is dropped on purpose
  assign accept_s   = (state_r == S_IDLE) && i_start && !fin_r;
  assign exp_bit_s  = P_MINUS_2[bit_idx_r];
  assign last_bit_s = (bit_idx_r == 8'd0);

  mod_mul u_mul (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (mul_start_r),
    .i_a        (mul_a_r),
    .i_b        (mul_b_r),
    .o_r        (mul_res_s),
    .o_finished (mul_done_s)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: every transition out of a busy state waits on mul done
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nxt_s = S_SQR;
        else          state_nxt_s = S_IDLE;
      end
      S_SQR: begin
        if (!mul_done_s)     state_nxt_s = S_SQR;
        else if (exp_bit_s)  state_nxt_s = S_MULZ;
        else if (last_bit_s) state_nxt_s = S_MULX;
        else                 state_nxt_s = S_SQR;
      end
      S_MULZ: begin
        if (!mul_done_s)     state_nxt_s = S_MULZ;
        else if (last_bit_s) state_nxt_s = S_MULX;
        else                 state_nxt_s = S_SQR;
      end
      S_MULX: begin
        if (mul_done_s) state_nxt_s = S_MULY;
        else            state_nxt_s = S_MULX;
      end
      S_MULY: begin
        if (mul_done_s) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_MULY;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output/control decode: next multiplier op and register load enables.
  // The freshly returned product is forwarded straight into the next op.
  always_comb begin
    issue_s    = 1'b0;
    acc_ld_s   = 1'b0;
    dec_s      = 1'b0;
    xh_ld_s    = 1'b0;
    done_out_s = 1'b0;
    op_a_s     = mul_res_s;
    op_b_s     = mul_res_s;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          issue_s = 1'b1;
          op_a_s  = i_z;
          op_b_s  = i_z;
        end else begin
          issue_s = 1'b0;
        end
      end
      S_SQR: begin
        if (mul_done_s) begin
          acc_ld_s = 1'b1;
          issue_s  = 1'b1;
          if (exp_bit_s) begin
            op_b_s = z_r;
          end else if (last_bit_s) begin
            op_a_s = x_r;
          end else begin
            dec_s = 1'b1;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      S_MULZ: begin
        if (mul_done_s) begin
          acc_ld_s = 1'b1;
          issue_s  = 1'b1;
          if (last_bit_s) begin
            op_a_s = x_r;
          end else begin
            dec_s = 1'b1;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      S_MULX: begin
        if (mul_done_s) begin
          xh_ld_s = 1'b1;
          issue_s = 1'b1;
          op_a_s  = y_r;
          op_b_s  = acc_r;
        end else begin
          issue_s = 1'b0;
        end
      end
      S_MULY: begin
        if (mul_done_s) done_out_s = 1'b1;
        else            done_out_s = 1'b0;
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  // Operand capture, accumulator and exponent bit counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_r         <= 255'd0;
      y_r         <= 255'd0;
      z_r         <= 255'd0;
      acc_r       <= 255'd0;
      xh_r        <= 255'd0;
      bit_idx_r   <= 8'd0;
      z_zero_r    <= 1'b0;
      mul_start_r <= 1'b0;
      mul_a_r     <= 255'd0;
      mul_b_r     <= 255'd0;
    end else begin
      mul_start_r <= issue_s;
      if (issue_s) begin
        mul_a_r <= op_a_s;
        mul_b_r <= op_b_s;
      end
      if (accept_s) begin
        x_r       <= i_x;
        y_r       <= i_y;
        z_r       <= i_z;
        acc_r     <= i_z;
        bit_idx_r <= 8'd253;
        z_zero_r  <= (i_z == 255'd0);
      end else begin
        if (acc_ld_s) acc_r <= mul_res_s;
        if (dec_s)    bit_idx_r <= bit_idx_r - 8'd1;
      end
      if (xh_ld_s) xh_r <= mul_res_s;
    end
  end

  // Registered outputs: results update only on completion
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ox_r   <= 255'd0;
      oy_r   <= 255'd0;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
      fin_r  <= 1'b0;
    end else begin
      fin_r <= done_out_s;
      err_r <= done_out_s & z_zero_r;
      if (done_out_s) begin
        ox_r <= xh_r;
        oy_r <= mul_res_s;
      end
      if (accept_s)        busy_r <= 1'b1;
      else if (done_out_s) busy_r <= 1'b0;
      else                 busy_r <= busy_r;
    end
  end

  assign o_x        = ox_r;
  assign o_y        = oy_r;
  assign o_busy     = busy_r;
  assign o_error    = err_r;
  assign o_finished = fin_r;

endmodule

// File: tb/tb_proj_to_affine.sv
// Self-checking bench for proj_to_affine with a field-arithmetic model.
module tb_proj_to_affine;

  typedef logic [254:0] fe_t;

  localparam int LAT = 508 * 2 + 1;
  localparam logic [255:0] PM = (256'd1 << 255) - 256'd19;
  localparam fe_t GXL =
    255'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
  localparam fe_t GYL =
    255'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
  localparam fe_t DL =
    255'h52036cee_2b6ffe73_8cc74079_7779e898_00700a4d_4141d8ab_75eb4dca_135978a3;
  localparam fe_t INV2 =
    255'h3fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  fe_t  x_in, y_in, z_in, ox, oy;
  logic busy, err, fin;

  proj_to_affine dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_x        (x_in),
    .i_y        (y_in),
    .i_z        (z_in),
    .o_x        (ox),
    .o_y        (oy),
    .o_busy     (busy),
    .o_error    (err),
    .o_finished (fin)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- field model ----------------
  function automatic fe_t fmul(input fe_t a, input fe_t b);
    logic [511:0] t;
    t = {257'd0, a} * {257'd0, b};
    t = t % {256'd0, PM};
    return t[254:0];
  endfunction

  function automatic fe_t fadd(input fe_t a, input fe_t b);
    logic [255:0] s;
    s = ({1'b0, a} + {1'b0, b}) % PM;
    return s[254:0];
  endfunction

  function automatic fe_t fsub(input fe_t a, input fe_t b);
    logic [255:0] s;
    s = ({1'b0, a} + PM - {1'b0, b}) % PM;
    return s[254:0];
  endfunction

  // Right-to-left binary exponentiation
  function automatic fe_t fpow(input fe_t b, input logic [255:0] e);
    fe_t r, base;
    r = 255'd1;
    base = b;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = fmul(r, base);
      base = fmul(base, base);
    end
    return r;
  endfunction

  function automatic fe_t finv(input fe_t a);
    return fpow(a, PM - 256'd2);
  endfunction

  function automatic fe_t frand();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r = r % PM;
    return r[254:0];
  endfunction

  task automatic chk(input string name, input fe_t act, input fe_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard state ----------------
  logic chk_en = 1'b0;
  logic pend = 1'b0;
  logic exp_err = 1'b0;
  fe_t exp_x = 255'd0, exp_y = 255'd0;
  fe_t hold_x = 255'd0, hold_y = 255'd0;
  int unsigned t0 = 0;
  int fin_cnt = 0;

  // Compare process: every cycle after reset, just past the clock edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      if (fin) begin
        fin_cnt++;
        n_cmp++;
        if (!pend) begin
          n_bad++;
          $display("FAIL unexpected_finished: got 1 want 0 (t=%0t)", $time);
        end else begin
          chk("latency", fe_t'(cyc - t0), fe_t'(LAT));
          chk("o_x", ox, exp_x);
          chk("o_y", oy, exp_y);
          chk("o_error", fe_t'(err), fe_t'(exp_err));
          hold_x = exp_x;
          hold_y = exp_y;
          pend = 1'b0;
        end
      end else begin
        chk("o_x_hold", ox, hold_x);
        chk("o_y_hold", oy, hold_y);
        chk("o_error_idle", fe_t'(err), 255'd0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic launch(input fe_t X, input fe_t Y, input fe_t Z);
    fe_t zi;
    @(negedge clk);
    zi = finv(Z);
    exp_x = fmul(X, zi);
    exp_y = fmul(Y, zi);
    exp_err = (Z == 255'd0);
    pend = 1'b1;
    t0 = cyc;
    x_in = X; y_in = Y; z_in = Z; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_in = frand(); y_in = frand(); z_in = frand();
    chk("busy_after_start", fe_t'(busy), 255'd1);
  endtask

  task automatic wait_fin();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < LAT + 50; i++) begin
      @(negedge clk);
      if (fin) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no o_finished want o_finished within %0d cycles", LAT + 50);
      pend = 1'b0;
    end
  endtask

  task automatic run(input fe_t X, input fe_t Y, input fe_t Z);
    launch(X, Y, Z);
    wait_fin();
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    fe_t a, b, z, x2, y2, den, t, k;
    int f0;
    rst = 1'b1; start = 1'b0; x_in = 255'd0; y_in = 255'd0; z_in = 255'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_o_x", ox, 255'd0);
    chk("rst_o_y", oy, 255'd0);
    chk("rst_busy", fe_t'(busy), 255'd0);
    chk("rst_err", fe_t'(err), 255'd0);
    chk("rst_fin", fe_t'(fin), 255'd0);

    // Pin the model with hand-known values
    chk("model_inv2", finv(255'd2), INV2);
    chk("model_z2", fmul(fmul(GXL, 255'd2), finv(255'd2)), GXL);
    chk("model_inv_sq", fmul(finv(255'd3), 255'd3), 255'd1);

    // Z = 1 identity
    f0 = fin_cnt;
    run(GXL, GYL, 255'd1);
    chk("z1_x", ox, GXL);
    chk("z1_y", oy, GYL);
    chk("z1_single_fin", fe_t'(fin_cnt - f0), 255'd1);

    // Z = 2 scaling of G
    run(fmul(GXL, 255'd2), fmul(GYL, 255'd2), 255'd2);
    chk("z2_x", ox, GXL);
    chk("z2_y", oy, GYL);

    // Z = 0 error case
    launch(255'd5, 255'd7, 255'd0);
    wait_fin();
    chk("z0_err", fe_t'(err), 255'd1);
    chk("z0_x", ox, 255'd0);
    chk("z0_y", oy, 255'd0);
    @(negedge clk);

    // Second start mid-run is ignored
    f0 = fin_cnt;
    a = frand(); b = frand(); z = frand() | 255'd1;
    launch(a, b, z);
    repeat (50) @(negedge clk);
    x_in = frand(); y_in = frand(); z_in = 255'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fin();
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("midstart_single_fin", fe_t'(fin_cnt - f0), 255'd1);

    // Start coincident with o_finished is ignored
    launch(frand(), frand(), frand() | 255'd2);
    wait_fin();
    x_in = frand(); y_in = frand(); z_in = 255'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_fin_ignored", fe_t'(busy), 255'd0);
    @(negedge clk);

    // Reset 100 cycles into a run
    f0 = fin_cnt;
    launch(frand(), frand(), frand() | 255'd4);
    repeat (98) @(negedge clk);
    rst = 1'b1;
    pend = 1'b0;
    hold_x = 255'd0;
    hold_y = 255'd0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_o_x", ox, 255'd0);
    chk("midrst_o_y", oy, 255'd0);
    chk("midrst_busy", fe_t'(busy), 255'd0);
    repeat (LAT) @(negedge clk);
    chk("midrst_no_fin", fe_t'(fin_cnt - f0), 255'd0);
    run(255'd11, 255'd13, 255'd17);

    // G in random projective form
    k = frand() | 255'd1;
    run(fmul(GXL, k), fmul(GYL, k), k);
    chk("chain_g_x", ox, GXL);

    // 2G from the affine doubling law, in random projective form
    t = fmul(DL, fmul(fmul(GXL, GXL), fmul(GYL, GYL)));
    den = finv(fadd(255'd1, t));
    x2 = fmul(fmul(255'd2, fmul(GXL, GYL)), den);
    y2 = fmul(fadd(fmul(GYL, GYL), fmul(GXL, GXL)), finv(fsub(255'd1, t)));
    k = frand() | 255'd1;
    run(fmul(x2, k), fmul(y2, k), k);
    chk("chain_2g_x", ox, x2);
    chk("chain_2g_y", oy, y2);

    // Random points
    for (int i = 0; i < 8; i++) begin
      z = frand();
      if (z == 255'd0) z = 255'd1;
      run(frand(), frand(), z);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
